limb_add_seq: RTL

Multi-limb addition sequencer that streams arbitrarily long operands through the team's combinational 64-bit adder one limb per cycle, least-significant limb first. It sits between the operand source and the result consumer: it accepts limb pairs on a valid/ready input stream and feeds them to the adder. It chains the adder's carry-out into the next limb's carry-in and delivers registered sum limbs plus the final carry on a valid/ready output stream.

---
 rtl/limb_add_pkg.sv | 24 ++
 rtl/limb_add_seq_adder.sv | 20 ++
 rtl/limb_add_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/limb_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : limb_add_pkg
// Purpose  : Shared types for the multi-limb addition sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package limb_add_pkg;

    localparam int LIMB_W = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width is a parameter of the top, so idx is attached there.
    typedef struct packed {
        logic [LIMB_W-1:0] sum;
        logic              last;
        logic              cout;
    } res_t;

endpackage
`default_nettype wire

// File: rtl/limb_add_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : adder_64
// Purpose  : Combinational 64-bit adder with carry-in and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module adder_64
    import limb_add_pkg::*;
(
    input  logic [LIMB_W-1:0] a_i,
    input  logic [LIMB_W-1:0] b_i,
    input  logic              cin_i,
    output logic [LIMB_W-1:0] sum_o,
    output logic              cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{LIMB_W{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/limb_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : limb_add_seq
// Purpose  : Streams multi-limb operands LS limb first through adder_64,
//            chaining carries; one registered output stage.
// Options  : LIMB_ADD_SUB_EN adds s_sub (A-B per operand).
// Revision : 1.0 - initial release
// ============================================================================
module limb_add_seq
    import limb_add_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LIMB_W-1:0] s_in1,
    input  logic [LIMB_W-1:0] s_in2,
    input  logic              s_cin,
    input  logic              s_last,
`ifdef LIMB_ADD_SUB_EN
    input  logic              s_sub,
`endif
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LIMB_W-1:0] m_sum,
    output logic              m_last,
    output logic              m_cout,
    output logic [IDX_W-1:0]  m_idx,
    output logic              err
);

    typedef struct packed {
        res_t             res;
        logic [IDX_W-1:0] idx;
    } out_t;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t           state_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic             valid_q;
    out_t             out_q;
    out_t             out_d;

    logic             w_accept;
    logic [IDX_W-1:0] w_cur_idx;
    logic [LIMB_W-1:0] w_b;
    logic             w_cin;
    logic [LIMB_W-1:0] w_sum;
    logic             w_cout;

    assign s_ready  = !valid_q || m_ready;
    assign w_accept = s_valid && s_ready;

    // In BUSY, idx_q is the index of the previously accepted limb.
    always_comb begin
        w_cur_idx = '0;
        if (state_q == BUSY) begin
            w_cur_idx = (idx_q == IDX_MAX) ? IDX_MAX : idx_q + IDX_W'(1);
        end
    end

`ifdef LIMB_ADD_SUB_EN
    logic sub_q;
    logic w_sub;

    assign w_sub = (state_q == IDLE) ? s_sub : sub_q;
    assign w_b   = w_sub ? ~s_in2 : s_in2;
    assign w_cin = (state_q == IDLE) ? (s_sub | s_cin) : carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (w_accept && state_q == IDLE) begin
            sub_q <= s_sub;
        end
    end
`else
    assign w_b   = s_in2;
    assign w_cin = (state_q == IDLE) ? s_cin : carry_q;
`endif

    adder_64 u_adder (
        .a_i    (s_in1),
        .b_i    (w_b),
        .cin_i  (w_cin),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    always_comb begin
        out_d          = out_q;
        out_d.res.sum  = w_sum;
        out_d.res.last = s_last;
        out_d.res.cout = s_last ? w_cout : 1'b0;
        out_d.idx      = w_cur_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            if (w_accept) begin
                valid_q <= 1'b1;
                out_q   <= out_d;
                carry_q <= w_cout;
                case (state_q)
                    IDLE: begin
                        idx_q <= '0;
                        if (!s_last) begin
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (s_last) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else if (idx_q == IDX_MAX) begin
                            err_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (m_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_valid = valid_q;
    assign m_sum   = out_q.res.sum;
    assign m_last  = out_q.res.last;
    assign m_cout  = out_q.res.cout;
    assign m_idx   = out_q.idx;
    assign err     = err_q;

endmodule
`default_nettype wire
